// File: rtl/dense_layer_pkg.sv
// Shared types and arithmetic helpers for the sequential dense layer:
// FSM state encoding, fixed-point width helpers and the output saturator.
package dense_layer_pkg;

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_FINISH = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   // Fractional bits of the fixed-point format.
   function automatic int frac_w(input int data_w, input int int_w);
      return data_w - int_w;
   endfunction

   // Accumulator wide enough for NUM_WEIGHT full-precision products.
   function automatic int acc_w(input int data_w, input int num_weight);
      return 2 * data_w + $clog2(num_weight);
   endfunction

   // Index width that stays at least one bit for single-entry ranges.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Clamp a wide signed value into the signed range of a dw-bit word.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int dw);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (dw - 1));
      if (v > max_v)      return max_v;
      else if (v < min_v) return min_v;
      else                return v;
   endfunction

endpackage

// File: rtl/dense_layer_mac.sv
// One neuron of the dense layer: weight row, bias, wide accumulator and the
// combinational finish path (bias add, arithmetic shift, saturate, activation).
module dense_layer_mac
   import dense_layer_pkg::*;
#(
   parameter int NUM_WEIGHT       = 30,
   parameter int DATA_WIDTH       = 16,
   parameter int WEIGHT_INT_WIDTH = 4,
   parameter int ACT_RELU         = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                w_we,
   input  logic [idx_w(NUM_WEIGHT)-1:0]        w_addr,
   input  logic [DATA_WIDTH-1:0]               w_data,
   input  logic                                b_we,
   input  logic [DATA_WIDTH-1:0]               b_data,
   input  logic                                acc_en,
   input  logic                                acc_clr,
   input  logic [idx_w(NUM_WEIGHT)-1:0]        rd_addr,
   input  logic [DATA_WIDTH-1:0]               x_in,
   output logic [DATA_WIDTH-1:0]               res
);

   localparam int FRAC  = frac_w(DATA_WIDTH, WEIGHT_INT_WIDTH);
   localparam int ACC_W = acc_w(DATA_WIDTH, NUM_WEIGHT);

   logic signed [DATA_WIDTH-1:0]   mem [NUM_WEIGHT];
   logic signed [DATA_WIDTH-1:0]   bias;
   logic signed [ACC_W-1:0]        acc;
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [63:0]             sum_w;
   logic signed [63:0]             shf_w;
   logic signed [63:0]             sat_w;

   assign prod = $signed(x_in) * mem[rd_addr];

   // Coefficient storage survives reset so a layer can be reused after reset.
   always_ff @(posedge clk) begin
      if (w_we) mem[w_addr] <= $signed(w_data);
      if (b_we) bias        <= $signed(b_data);
   end

   // Full-precision accumulation; cleared when the frame has been drained.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         acc <= '0;
      else if (acc_clr) acc <= '0;
      else if (acc_en)  acc <= acc + ACC_W'(prod);
   end

   // Finish arithmetic: bias aligned to the product scale, rescale, clamp, activate.
   always_comb begin
      sum_w = 64'(acc) + (64'(bias) <<< FRAC);
      shf_w = sum_w >>> FRAC;
      sat_w = saturate(shf_w, DATA_WIDTH);
      res   = sat_w[DATA_WIDTH-1:0];
      if (ACT_RELU != 0 && sat_w < 0) res = '0;
   end

endmodule

// File: rtl/dense_layer_seq.sv
// Sequential dense layer: streams NUM_WEIGHT inputs into NN parallel MACs,
// finishes in one cycle, then drains results serially with a valid/ready port.
// Optional feature macro: DENSE_LAYER_ARGMAX_EN adds argmax_idx/argmax_valid.
module dense_layer_seq
   import dense_layer_pkg::*;
#(
   parameter int NN               = 10,
   parameter int NUM_WEIGHT       = 30,
   parameter int DATA_WIDTH       = 16,
   parameter int WEIGHT_INT_WIDTH = 4,
   parameter int LAYER_NUM        = 4,
   parameter int ACT_RELU         = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       weight_valid,
   input  logic                       bias_valid,
   input  logic [31:0]                weight_value,
   input  logic [31:0]                bias_value,
   input  logic [31:0]                config_layer_num,
   input  logic [31:0]                config_neuron_num,
   input  logic                       x_valid,
   output logic                       x_ready,
   input  logic [DATA_WIDTH-1:0]      x_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic [idx_w(NN)-1:0]       out_idx,
   output logic [NN*DATA_WIDTH-1:0]  x_out,
   output logic                       layer_done
`ifdef DENSE_LAYER_ARGMAX_EN
   ,
   output logic [idx_w(NN)-1:0]       argmax_idx,
   output logic                       argmax_valid
`endif
);

   localparam int IW = idx_w(NN);
   localparam int AW = idx_w(NUM_WEIGHT);

   state_t                  state_q, state_d;
   logic [AW-1:0]           in_cnt_q;
   logic [AW-1:0]           w_addr_q;
   logic [IW-1:0]           idx_q;
   logic                    acc_en;
   logic                    acc_clr;
   logic                    cfg_hit;
   logic                    w_accept;
   logic                    b_accept;
   logic                    in_last;
   logic                    idx_last;
   logic [DATA_WIDTH-1:0]   res [NN];
   logic                    unused_hi;

   assign unused_hi = ^{weight_value[31:DATA_WIDTH], bias_value[31:DATA_WIDTH]};

   assign cfg_hit  = (config_layer_num == 32'(LAYER_NUM)) && (config_neuron_num < 32'(NN));
   assign w_accept = weight_valid && cfg_hit;
   assign b_accept = bias_valid && cfg_hit;
   assign in_last  = (in_cnt_q == AW'(NUM_WEIGHT - 1));
   assign idx_last = (idx_q == IW'(NN - 1));

   assign out_data = x_out[idx_q*DATA_WIDTH +: DATA_WIDTH];
   assign out_idx  = idx_q;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_ACCUM;
      else      state_q <= state_d;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      x_ready   = 1'b0;
      out_valid = 1'b0;
      acc_en    = 1'b0;
      acc_clr   = 1'b0;
      case (state_q)
         ST_ACCUM: begin
            x_ready = 1'b1;
            acc_en  = x_valid;
            if (x_valid && in_last) state_d = ST_FINISH;
         end
         ST_FINISH: state_d = ST_DRAIN;
         ST_DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && idx_last) begin
               state_d = ST_ACCUM;
               acc_clr = 1'b1;
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   // Input, write-address and drain-index counters plus the done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_cnt_q   <= '0;
         w_addr_q   <= '0;
         idx_q      <= '0;
         layer_done <= 1'b0;
      end else begin
         layer_done <= (state_q == ST_FINISH);
         if (w_accept)
            w_addr_q <= (w_addr_q == AW'(NUM_WEIGHT - 1)) ? '0 : w_addr_q + 1'b1;
         if (acc_en)
            in_cnt_q <= in_last ? '0 : in_cnt_q + 1'b1;
         if (state_q == ST_DRAIN && out_ready)
            idx_q <= idx_last ? '0 : idx_q + 1'b1;
      end
   end

   // Parallel result bank, captured once per frame at FINISH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_out <= '0;
      end else if (state_q == ST_FINISH) begin
         for (int k = 0; k < NN; k++) x_out[k*DATA_WIDTH +: DATA_WIDTH] <= res[k];
      end
   end

   for (genvar k = 0; k < NN; k++) begin : g_neuron
      dense_layer_mac #(
         .NUM_WEIGHT       (NUM_WEIGHT),
         .DATA_WIDTH       (DATA_WIDTH),
         .WEIGHT_INT_WIDTH (WEIGHT_INT_WIDTH),
         .ACT_RELU         (ACT_RELU)
      ) u_mac (
         .clk     (clk),
         .rst     (rst),
         .w_we    (w_accept && (config_neuron_num == 32'(k))),
         .w_addr  (w_addr_q),
         .w_data  (weight_value[DATA_WIDTH-1:0]),
         .b_we    (b_accept && (config_neuron_num == 32'(k))),
         .b_data  (bias_value[DATA_WIDTH-1:0]),
         .acc_en  (acc_en),
         .acc_clr (acc_clr),
         .rd_addr (in_cnt_q),
         .x_in    (x_in),
         .res     (res[k])
      );
   end

`ifdef DENSE_LAYER_ARGMAX_EN
   logic [IW-1:0] best_idx;

   // Strictly-greater search so the lowest index wins ties.
   always_comb begin
      best_idx = '0;
      for (int k = 1; k < NN; k++)
         if ($signed(res[k]) > $signed(res[best_idx])) best_idx = IW'(k);
   end

   // Argmax is registered alongside the result bank so it aligns with layer_done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         argmax_idx   <= '0;
         argmax_valid <= 1'b0;
      end else begin
         argmax_valid <= (state_q == ST_FINISH);
         if (state_q == ST_FINISH) argmax_idx <= best_idx;
      end
   end
`endif

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench for dense_layer_seq: two instances (ReLU and identity) share
// stimulus; a model-driven scoreboard queue supplies expected drained results.
module tb_dense_layer_seq;

   localparam int NN = 2;
   localparam int NW = 3;
   localparam int DW = 16;
   localparam int LN = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              weight_valid, bias_valid;
   logic [31:0]       weight_value, bias_value, config_layer_num, config_neuron_num;
   logic              x_valid;
   logic [DW-1:0]     x_in;
   logic              out_ready;

   logic              x_ready_r, x_ready_l;
   logic              out_valid_r, out_valid_l;
   logic [DW-1:0]     out_data_r, out_data_l;
   logic [0:0]        out_idx_r, out_idx_l;
   logic [NN*DW-1:0]  x_out_r, x_out_l;
   logic              layer_done_r, layer_done_l;
`ifdef DENSE_LAYER_ARGMAX_EN
   logic [0:0]        amax_r, amax_l;
   logic              amax_v_r, amax_v_l;
`endif

   dense_layer_seq #(.NN(NN), .NUM_WEIGHT(NW), .DATA_WIDTH(DW), .WEIGHT_INT_WIDTH(4),
                     .LAYER_NUM(LN), .ACT_RELU(1)) u_relu (
      .clk(clk), .rst(rst), .weight_valid(weight_valid), .bias_valid(bias_valid),
      .weight_value(weight_value), .bias_value(bias_value),
      .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
      .x_valid(x_valid), .x_ready(x_ready_r), .x_in(x_in),
      .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
      .out_idx(out_idx_r), .x_out(x_out_r), .layer_done(layer_done_r)
`ifdef DENSE_LAYER_ARGMAX_EN
      , .argmax_idx(amax_r), .argmax_valid(amax_v_r)
`endif
   );

   dense_layer_seq #(.NN(NN), .NUM_WEIGHT(NW), .DATA_WIDTH(DW), .WEIGHT_INT_WIDTH(4),
                     .LAYER_NUM(LN), .ACT_RELU(0)) u_lin (
      .clk(clk), .rst(rst), .weight_valid(weight_valid), .bias_valid(bias_valid),
      .weight_value(weight_value), .bias_value(bias_value),
      .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
      .x_valid(x_valid), .x_ready(x_ready_l), .x_in(x_in),
      .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
      .out_idx(out_idx_l), .x_out(x_out_l), .layer_done(layer_done_l)
`ifdef DENSE_LAYER_ARGMAX_EN
      , .argmax_idx(amax_l), .argmax_valid(amax_v_l)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] tw [NN][NW];
   logic [DW-1:0] tb [NN];
   logic [DW-1:0] tx [NW];

   logic [DW-1:0] q_relu [$];
   logic [DW-1:0] q_lin  [$];
   int            q_idx  [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference arithmetic: exact sum of products, bias at product scale,
   // floor shift back to the data format, clamp, optional ReLU.
   function automatic logic [DW-1:0] model(input int n, input bit relu);
      longint acc;
      longint s;
      acc = 0;
      for (int i = 0; i < NW; i++)
         acc += longint'($signed(tw[n][i])) * longint'($signed(tx[i]));
      s = acc + (longint'($signed(tb[n])) <<< 12);
      s = s >>> 12;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      if (relu && s < 0) s = 0;
      return s[DW-1:0];
   endfunction

   task automatic wr(input bit is_bias, input int layer, input int neuron, input logic [DW-1:0] val);
      @(negedge clk);
      config_layer_num  = layer;
      config_neuron_num = neuron;
      weight_value      = {16'hABCD, val};
      bias_value        = {16'h5A5A, val};
      weight_valid      = !is_bias;
      bias_valid        = is_bias;
      @(negedge clk);
      weight_valid      = 1'b0;
      bias_valid        = 1'b0;
   endtask

   task automatic load();
      for (int n = 0; n < NN; n++)
         for (int i = 0; i < NW; i++) wr(1'b0, LN, n, tw[n][i]);
      for (int n = 0; n < NN; n++) wr(1'b1, LN, n, tb[n]);
   endtask

   task automatic push_expected();
      for (int n = 0; n < NN; n++) begin
         q_relu.push_back(model(n, 1'b1));
         q_lin.push_back(model(n, 1'b0));
         q_idx.push_back(n);
      end
   endtask

   task automatic feed();
      for (int i = 0; i < NW; i++) begin
         @(negedge clk);
         check("x_ready_accum", x_ready_r, 1);
         x_in    = tx[i];
         x_valid = 1'b1;
      end
      @(negedge clk);
      x_valid = 1'b0;
   endtask

   task automatic wait_done();
      int c;
      c = 0;
      while (out_valid_r !== 1'b1 && c < 20) begin
         @(negedge clk);
         c++;
      end
      check("drain_reached", out_valid_r, 1);
      check("layer_done_relu", layer_done_r, 1);
      check("layer_done_lin", layer_done_l, 1);
      check("x_ready_drain", x_ready_r, 0);
      for (int n = 0; n < NN; n++) begin
         check("x_out_relu", x_out_r[n*DW +: DW], q_relu[n]);
         check("x_out_lin", x_out_l[n*DW +: DW], q_lin[n]);
      end
`ifdef DENSE_LAYER_ARGMAX_EN
      check("argmax_valid", amax_v_r, 1);
      check("argmax_idx", amax_r, ($signed(q_relu[1]) > $signed(q_relu[0])) ? 1 : 0);
`endif
      @(negedge clk);
      check("layer_done_pulse", layer_done_r, 0);
   endtask

   task automatic drain(input int stall);
      x_valid = 1'b1;
      x_in    = 16'h7FFF;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check("stall_out_valid", out_valid_r, 1);
         check("stall_out_idx", out_idx_r, 0);
         check("stall_out_data", out_data_r, q_relu[0]);
         check("stall_x_ready", x_ready_r, 0);
      end
      x_valid = 1'b0;
      for (int n = 0; n < NN; n++) begin
         check("out_valid", out_valid_r, 1);
         check("out_data_relu", out_data_r, q_relu.pop_front());
         check("out_data_lin", out_data_l, q_lin.pop_front());
         check("out_idx", out_idx_r, q_idx.pop_front());
         out_ready = 1'b1;
         @(negedge clk);
      end
      out_ready = 1'b0;
      check("post_drain_out_valid", out_valid_r, 0);
      check("post_drain_x_ready", x_ready_r, 1);
   endtask

   task automatic frame(input int stall);
      push_expected();
      feed();
      wait_done();
      drain(stall);
   endtask

   initial begin
      rst = 1'b0;
      weight_valid = 1'b0; bias_valid = 1'b0;
      weight_value = '0; bias_value = '0;
      config_layer_num = '0; config_neuron_num = '0;
      x_valid = 1'b0; x_in = '0; out_ready = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid_r, 0);
      check("rst_layer_done", layer_done_r, 0);
      check("rst_x_out", x_out_r, 0);
      check("rst_out_idx", out_idx_r, 0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_x_ready", x_ready_r, 1);

      // Unit weights, ramp input: 1+2+3 = 6.0 on both neurons.
      for (int n = 0; n < NN; n++) begin
         for (int i = 0; i < NW; i++) tw[n][i] = 16'h1000;
         tb[n] = 16'h0000;
      end
      tx[0] = 16'h1000; tx[1] = 16'h2000; tx[2] = 16'h3000;
      load();
      check("const_6p0", model(0, 1'b1), 16'h6000);
      frame(0);

      // Negative weights: ReLU clamps to zero, identity gives -3.0.
      for (int n = 0; n < NN; n++)
         for (int i = 0; i < NW; i++) tw[n][i] = 16'hF000;
      for (int i = 0; i < NW; i++) tx[i] = 16'h1000;
      load();
      check("const_neg3", model(0, 1'b0), 16'hD000);
      frame(0);

      // 7.0 * 7.0 * 3 exceeds the format: positive saturation.
      for (int n = 0; n < NN; n++)
         for (int i = 0; i < NW; i++) tw[n][i] = 16'h7000;
      for (int i = 0; i < NW; i++) tx[i] = 16'h7000;
      load();
      check("const_sat", model(0, 1'b1), 16'h7FFF);
      frame(0);

      // Neuron 0 negative saturation, neuron 1 mixed weights with bias (1.75).
      for (int i = 0; i < NW; i++) tw[0][i] = 16'h8000;
      tb[0] = 16'h0000;
      tw[1][0] = 16'h0800; tw[1][1] = 16'hE000; tw[1][2] = 16'h1400;
      tb[1] = 16'h1800;
      tx[0] = 16'h1000; tx[1] = 16'h2000; tx[2] = 16'h3000;
      load();
      check("const_mixed", model(1, 1'b1), 16'h1C00);
      frame(5);

      // Writes addressed to another layer or an absent neuron must be ignored.
      wr(1'b0, LN + 1, 0, 16'h7000);
      wr(1'b1, LN + 1, 1, 16'h7000);
      wr(1'b0, LN, 2, 16'h7000);
      wr(1'b1, LN, 5, 16'h7000);
      frame(0);

      // Reset while draining discards the frame; next frame is clean.
      tx[0] = 16'h3000; tx[1] = 16'h1000; tx[2] = 16'hF000;
      push_expected();
      feed();
      wait_done();
      rst = 1'b0;
      #1;
      check("rst_drain_out_valid", out_valid_r, 0);
      check("rst_drain_x_out", x_out_r, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_drain_x_ready", x_ready_r, 1);
      check("rst_drain_layer_done", layer_done_r, 0);
      q_relu.delete(); q_lin.delete(); q_idx.delete();
      frame(0);

      // Reset part-way through accumulation discards the partial sum.
      @(negedge clk);
      x_in = 16'h7000; x_valid = 1'b1;
      @(negedge clk);
      x_in = 16'h6000;
      @(negedge clk);
      x_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      frame(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
